// File: rtl/obi_arb2_if.sv
// One OBI link (address phase + response phase) between an initiator and a target.
// Carries no state; the master modport drives the request side, the slave modport answers.
interface obi_arb2_if #(
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [3:0]    be;
    logic          req_isr;
    logic [31:0]   addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          err;

    modport master (
        output req, we, be, req_isr, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, be, req_isr, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/obi_arb2.sv
// Two-master OBI arbiter with in-order tag FIFO; request path and response routing are both zero-latency.
// Requests stall (s.req low) once MAX_OUT transactions are outstanding, unless a response frees a slot that cycle.
module obi_arb2_fifo #(
    parameter  int W     = 1,
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          empty
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
endmodule

module obi_arb2 #(
    parameter int DW         = 32,
    parameter int MAX_OUT    = 4,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    obi_arb2_if.slave    m0,
    obi_arb2_if.slave    m1,
    obi_arb2_if.master   s,
    output logic         busy,
    output logic         err_unexp
);
    localparam int CW = $clog2(MAX_OUT + 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t        state, state_nxt;
    logic          owner, owner_nxt;
    logic          rr_ptr, rr_nxt;
    logic          sel;
    logic          sel_req;
    logic          hs;
    logic          blocked;
    logic          head;
    logic          fifo_empty;
    logic          pop;
    logic          rv_ok;
    logic [CW-1:0] out_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            rr_ptr    <= 1'b0;
            err_unexp <= 1'b0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_nxt;
            if (s.rvalid && fifo_empty) begin
                err_unexp <= 1'b1;
            end
        end
    end

    // A pending, ungranted request pins the owner so its address phase stays stable.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        rr_nxt    = rr_ptr;
        sel       = 1'b0;
        if (state == LOCKED) begin
            sel = owner;
        end else if (m0.req && m1.req) begin
            sel = FIXED_PRIO ? 1'b0 : rr_ptr;
        end else begin
            sel = m1.req;
        end
        sel_req = sel ? m1.req : m0.req;
        s.req   = sel_req & ~blocked & ~rst;
        hs      = s.req & s.gnt;
        case (state)
            IDLE: begin
                if (s.req && !s.gnt) begin
                    state_nxt = LOCKED;
                    owner_nxt = sel;
                end
            end
            LOCKED: begin
                if (hs) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (hs) begin
            rr_nxt = ~sel;
        end
    end

    // A response arriving this cycle frees a slot for a same-cycle grant.
    assign blocked = (out_cnt == CW'(MAX_OUT)) & ~s.rvalid;

    assign s.we      = sel ? m1.we      : m0.we;
    assign s.be      = sel ? m1.be      : m0.be;
    assign s.req_isr = sel ? m1.req_isr : m0.req_isr;
    assign s.addr    = sel ? m1.addr    : m0.addr;
    assign s.wdata   = sel ? m1.wdata   : m0.wdata;

    assign m0.gnt = hs & ~sel;
    assign m1.gnt = hs & sel;

    assign pop   = s.rvalid & ~fifo_empty;
    assign rv_ok = pop & ~rst;

    obi_arb2_fifo #(
        .W     (1),
        .DEPTH (MAX_OUT)
    ) u_tags (
        .clk   (clk),
        .rst   (rst),
        .push  (hs),
        .pop   (pop),
        .din   (sel),
        .dout  (head),
        .count (out_cnt),
        .empty (fifo_empty)
    );

    assign m0.rvalid = rv_ok & ~head;
    assign m1.rvalid = rv_ok & head;
    assign m0.err    = s.err & m0.rvalid;
    assign m1.err    = s.err & m1.rvalid;
    assign m0.rdata  = m0.rvalid ? s.rdata : {DW{1'b0}};
    assign m1.rdata  = m1.rvalid ? s.rdata : {DW{1'b0}};

    assign busy = (out_cnt != '0);
endmodule
